// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: measures incoming line/frame geometry, qualifies it against
// the expected timing, and emits coordinate-tagged RGB332 pixels once locked.
module vga_timing_receiver #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FRONT     = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BACK      = 88,
    parameter int V_ACTIVE    = 600,
    parameter int V_FRONT     = 1,
    parameter int V_SYNC      = 4,
    parameter int V_BACK      = 23,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_pix_clk,
    input  logic        i_reset,
    input  logic        i_horz_sync,
    input  logic        i_vert_sync,
    input  logic [2:0]  i_red,
    input  logic [2:0]  i_green,
    input  logic [1:0]  i_blue,
    output logic [15:0] o_horz_coord,
    output logic [15:0] o_vert_coord,
    output logic        o_in_active_area,
    output logic [2:0]  o_red,
    output logic [2:0]  o_green,
    output logic [1:0]  o_blue,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic        o_sync_error,
    output logic [15:0] o_line_len,
    output logic [15:0] o_frame_lines
);

    localparam logic [15:0] H_TOTAL_W = 16'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [15:0] V_TOTAL_W = 16'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [15:0] H_START_W = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] H_END_W   = 16'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [15:0] V_START_W = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] V_END_W   = 16'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [7:0]  LOCK_W    = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
    logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic [7:0]  rgb1_q, rgb1_d, rgb2_q, rgb2_d, rgb_out_q, rgb_out_d;
    logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [15:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic [15:0] horz_coord_q, horz_coord_d, vert_coord_q, vert_coord_d;
    logic [7:0]  good_q, good_d, good_inc;
    logic        bad_q, bad_d;
    logic        frame_start_q, frame_start_d, sync_error_q, sync_error_d;
    logic        active_q, active_d;
    logic        h_edge, v_edge, line_bad, frame_bad, h_win, v_win;
    logic [15:0] h_len, v_len;

    // Next-state logic: sync sampling, counters, lock FSM and output stage.
    always_comb begin
        hs_d      = i_horz_sync ^ ~SYNC_POL;
        vs_d      = i_vert_sync ^ ~SYNC_POL;
        hs_prev_d = hs_q;
        vs_prev_d = vs_q;
        rgb1_d    = {i_red, i_green, i_blue};
        rgb2_d    = rgb1_q;

        h_edge = hs_q & ~hs_prev_q;
        v_edge = vs_q & ~vs_prev_q;
        h_len  = (h_cnt_q == 16'hFFFF) ? 16'hFFFF : h_cnt_q + 16'd1;
        v_len  = (v_cnt_q == 16'hFFFF) ? 16'hFFFF : v_cnt_q + 16'd1;

        h_cnt_d       = h_edge ? 16'd0 : h_len;
        v_cnt_d       = v_edge ? 16'd0 : (h_edge ? v_len : v_cnt_q);
        line_len_d    = h_edge ? h_len : line_len_q;
        frame_lines_d = v_edge ? v_len : frame_lines_q;
        frame_start_d = v_edge;

        line_bad  = h_edge && (h_len != H_TOTAL_W);
        frame_bad = v_edge && (v_len != V_TOTAL_W);
        good_inc  = good_q + 8'd1;

        state_d      = state_q;
        good_d       = good_q;
        bad_d        = bad_q;
        sync_error_d = 1'b0;
        // The line closing at the vsync edge still counts toward that frame.
        case (state_q)
            ST_SEARCH: begin
                if (v_edge) begin
                    state_d = ST_MEASURE;
                    good_d  = 8'd0;
                    bad_d   = 1'b0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (v_edge) begin
                    bad_d = 1'b0;
                    if (!bad_q && !line_bad && !frame_bad) begin
                        good_d = good_inc;
                        if (good_inc >= LOCK_W) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_MEASURE;
                        end
                    end else begin
                        good_d = 8'd0;
                    end
                end else if (line_bad) begin
                    bad_d = 1'b1;
                end else begin
                    bad_d = bad_q;
                end
            end
            ST_LOCKED: begin
                if (line_bad || frame_bad) begin
                    state_d      = ST_SEARCH;
                    sync_error_d = 1'b1;
                    good_d       = 8'd0;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = 8'd0;
                bad_d   = 1'b0;
            end
        endcase

        h_win        = (h_cnt_q >= H_START_W) && (h_cnt_q < H_END_W);
        v_win        = (v_cnt_q >= V_START_W) && (v_cnt_q < V_END_W);
        horz_coord_d = h_win ? (h_cnt_q - H_START_W) : 16'd0;
        vert_coord_d = v_win ? (v_cnt_q - V_START_W) : 16'd0;
        active_d     = h_win && v_win && (state_q == ST_LOCKED);
        rgb_out_d    = rgb2_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            state_q       <= ST_SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            rgb1_q        <= 8'd0;
            rgb2_q        <= 8'd0;
            rgb_out_q     <= 8'd0;
            h_cnt_q       <= 16'd0;
            v_cnt_q       <= 16'd0;
            line_len_q    <= 16'd0;
            frame_lines_q <= 16'd0;
            horz_coord_q  <= 16'd0;
            vert_coord_q  <= 16'd0;
            good_q        <= 8'd0;
            bad_q         <= 1'b0;
            frame_start_q <= 1'b0;
            sync_error_q  <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            rgb1_q        <= rgb1_d;
            rgb2_q        <= rgb2_d;
            rgb_out_q     <= rgb_out_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            horz_coord_q  <= horz_coord_d;
            vert_coord_q  <= vert_coord_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            frame_start_q <= frame_start_d;
            sync_error_q  <= sync_error_d;
            active_q      <= active_d;
        end
    end

    assign o_horz_coord     = horz_coord_q;
    assign o_vert_coord     = vert_coord_q;
    assign o_in_active_area = active_q;
    assign o_red            = rgb_out_q[7:5];
    assign o_green          = rgb_out_q[4:2];
    assign o_blue           = rgb_out_q[1:0];
    assign o_locked         = (state_q == ST_LOCKED);
    assign o_frame_start    = frame_start_q;
    assign o_sync_error     = sync_error_q;
    assign o_line_len       = line_len_q;
    assign o_frame_lines    = frame_lines_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver on a scaled-down raster (16x9 total), with an
// active-high and an active-low instance fed the same stream.
module tb_vga_timing_receiver;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LOCKF = 2;
    localparam int MAXS = 4095;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs = 1'b0, vs = 1'b0;
    logic [2:0] red = 3'd0, green = 3'd0;
    logic [1:0] blue = 2'd0;

    logic [15:0] a_hc, a_vc, a_ll, a_fl, b_hc, b_vc, b_ll, b_fl;
    logic        a_act, a_lk, a_fs, a_err, b_act, b_lk, b_fs, b_err;
    logic [2:0]  a_r, a_g, b_r, b_g;
    logic [1:0]  a_b, b_b;

    always #5 clk = ~clk;

    vga_timing_receiver #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b1), .LOCK_FRAMES(LOCKF)) dut_a (
        .i_pix_clk(clk), .i_reset(rst), .i_horz_sync(hs), .i_vert_sync(vs),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_horz_coord(a_hc), .o_vert_coord(a_vc), .o_in_active_area(a_act),
        .o_red(a_r), .o_green(a_g), .o_blue(a_b), .o_locked(a_lk),
        .o_frame_start(a_fs), .o_sync_error(a_err), .o_line_len(a_ll),
        .o_frame_lines(a_fl));

    vga_timing_receiver #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .LOCK_FRAMES(LOCKF)) dut_b (
        .i_pix_clk(clk), .i_reset(rst), .i_horz_sync(~hs), .i_vert_sync(~vs),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_horz_coord(b_hc), .o_vert_coord(b_vc), .o_in_active_area(b_act),
        .o_red(b_r), .o_green(b_g), .o_blue(b_b), .o_locked(b_lk),
        .o_frame_start(b_fs), .o_sync_error(b_err), .o_line_len(b_ll),
        .o_frame_lines(b_fl));

    int n_checks = 0;
    int n_fail = 0;
    int k = 0;
    bit in_rst = 1'b1;
    bit started = 1'b0;
    bit lit_done = 1'b0;

    // Model state: sample index of last line start, lock mode and frame bookkeeping.
    int last_h, mode, good;
    bit bad, hs_p, vs_p;
    int res_h[0:MAXS], res_v[0:MAXS], res_ll[0:MAXS], res_fl[0:MAXS];
    bit res_lk[0:MAXS], res_fs[0:MAXS], res_err[0:MAXS];
    logic [2:0] res_r[0:MAXS], res_g[0:MAXS];
    logic [1:0] res_b[0:MAXS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    // One model step per sampled input; sample 0 stands for the cleared input stage.
    task automatic model_step();
        int ll, fl;
        bit he, ve, lbad, fbad, err;
        if (rst) begin
            k = 0; in_rst = 1'b1; last_h = -1; mode = 0; good = 0; bad = 1'b0;
            hs_p = 1'b0; vs_p = 1'b0;
            res_h[0] = 1; res_v[0] = 0; res_ll[0] = 0; res_fl[0] = 0;
            res_lk[0] = 1'b0; res_fs[0] = 1'b0; res_err[0] = 1'b0;
            res_r[0] = 3'd0; res_g[0] = 3'd0; res_b[0] = 2'd0;
        end else if (k < MAXS) begin
            in_rst = 1'b0;
            k++;
            he = hs && !hs_p;
            ve = vs && !vs_p;
            hs_p = hs; vs_p = vs;
            ll = res_ll[k-1];
            fl = res_fl[k-1];
            err = 1'b0;
            if (he) begin
                ll = sat(k - last_h);
                last_h = k;
            end
            res_h[k] = sat(k - last_h);
            if (ve) fl = sat(res_v[k-1] + 1);
            res_v[k] = ve ? 0 : (he ? sat(res_v[k-1] + 1) : res_v[k-1]);
            lbad = he && (ll != HT);
            fbad = ve && (fl != VT);
            if (mode == 0) begin
                if (ve) begin mode = 1; good = 0; bad = 1'b0; end
            end else if (mode == 1) begin
                if (ve) begin
                    if (!bad && !lbad && !fbad) begin
                        good++;
                        if (good >= LOCKF) mode = 2;
                    end else begin
                        good = 0;
                    end
                    bad = 1'b0;
                end else if (lbad) begin
                    bad = 1'b1;
                end
            end else if (lbad || fbad) begin
                mode = 0; err = 1'b1;
            end
            res_ll[k] = ll; res_fl[k] = fl; res_lk[k] = (mode == 2);
            res_fs[k] = ve; res_err[k] = err;
            res_r[k] = red; res_g[k] = green; res_b[k] = blue;
        end
    endtask

    initial forever begin
        @(posedge clk);
        started = 1'b1;
        model_step();
    end

    task automatic cmp_dut(input string t, input logic [15:0] hc, input logic [15:0] vc,
                           input logic act, input logic [2:0] r, input logic [2:0] g,
                           input logic [1:0] b, input logic lk, input logic fs,
                           input logic err, input logic [15:0] ll, input logic [15:0] fl);
        int m1, m2, h, v, ec, er;
        bit hw, vw, ea;
        logic [2:0] xr, xg;
        logic [1:0] xb;
        m1 = k - 1;
        m2 = k - 2;
        ec = 0; er = 0; ea = 1'b0; xr = 3'd0; xg = 3'd0; xb = 2'd0;
        if (!in_rst && m2 >= 0) begin
            h = res_h[m2]; v = res_v[m2];
            hw = (h >= HS + HB) && (h < HS + HB + HA);
            vw = (v >= VS + VB) && (v < VS + VB + VA);
            ec = hw ? h - (HS + HB) : 0;
            er = vw ? v - (VS + VB) : 0;
            ea = hw && vw && res_lk[m2];
            xr = res_r[m2]; xg = res_g[m2]; xb = res_b[m2];
        end
        chk({t, "horz_coord"}, hc, ec);
        chk({t, "vert_coord"}, vc, er);
        chk({t, "active"}, act, ea);
        chk({t, "red"}, r, xr);
        chk({t, "green"}, g, xg);
        chk({t, "blue"}, b, xb);
        if (in_rst || m1 < 0) begin
            chk({t, "locked"}, lk, 0); chk({t, "frame_start"}, fs, 0);
            chk({t, "sync_error"}, err, 0); chk({t, "line_len"}, ll, 0);
            chk({t, "frame_lines"}, fl, 0);
        end else begin
            chk({t, "locked"}, lk, res_lk[m1]); chk({t, "frame_start"}, fs, res_fs[m1]);
            chk({t, "sync_error"}, err, res_err[m1]); chk({t, "line_len"}, ll, res_ll[m1]);
            chk({t, "frame_lines"}, fl, res_fl[m1]);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (started) begin
            cmp_dut("a_", a_hc, a_vc, a_act, a_r, a_g, a_b, a_lk, a_fs, a_err, a_ll, a_fl);
            cmp_dut("b_", b_hc, b_vc, b_act, b_r, b_g, b_b, b_lk, b_fs, b_err, b_ll, b_fl);
        end
    end

    task automatic drive(input logic h, input logic v, input logic [2:0] r,
                         input logic [2:0] g, input logic [1:0] b);
        hs = h; vs = v; red = r; green = g; blue = b;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_line(input int len, input bit vact, input int ln, input int sp);
        for (int i = 0; i < len; i++) begin
            if (i == sp) drive(i < HS, vact, 3'b101, 3'b010, 2'b11);
            else drive(i < HS, vact, 3'(i), 3'(ln), 2'(i + ln));
        end
    endtask

    task automatic gen_frame(input int nlines, input int bad_line, input int sp_line);
        for (int l = 0; l < nlines; l++)
            gen_line((l == bad_line) ? HT - 1 : HT, l < VS, l, (l == sp_line) ? HS + HB : -1);
    endtask

    task automatic at_cyc(input int c);
        do @(negedge clk); while (in_rst || k < c);
    endtask

    // Hand-computed checkpoints on the scaled raster (frame f starts at sample 1+144f).
    initial begin
        at_cyc(2);    chk("frame_start_first", a_fs, 1);
        at_cyc(3);    chk("frame_start_width", a_fs, 0);
        at_cyc(289);  chk("lock_a_early", a_lk, 0); chk("lock_b_early", b_lk, 0);
        at_cyc(290);  chk("lock_a_rise", a_lk, 1); chk("lock_b_rise", b_lk, 1);
        at_cyc(300);  chk("line_len_ideal", a_ll, HT); chk("frame_lines_ideal", a_fl, VT);
        at_cyc(361);  chk("first_px_col", a_hc, 0); chk("first_px_row", a_vc, 0);
                      chk("first_px_active", a_act, 1); chk("first_px_red", a_r, 5);
                      chk("first_px_green", a_g, 2); chk("first_px_blue", a_b, 3);
                      chk("first_px_b_col", b_hc, 0); chk("first_px_b_active", b_act, 1);
        at_cyc(368);  chk("last_px_col", a_hc, HA - 1); chk("last_px_active", a_act, 1);
        at_cyc(369);  chk("after_px_active", a_act, 0); chk("after_px_col", a_hc, 0);
        at_cyc(528);  chk("err_before", a_err, 0); chk("lock_before_err", a_lk, 1);
        at_cyc(529);  chk("err_pulse", a_err, 1); chk("lock_dropped", a_lk, 0);
                      chk("short_line_len", a_ll, HT - 1); chk("err_pulse_b", b_err, 1);
        at_cyc(530);  chk("err_width", a_err, 0);
        at_cyc(864);  chk("relock_early", a_lk, 0);
        at_cyc(865);  chk("relock", a_lk, 1); chk("relock_b", b_lk, 1);
        at_cyc(1056); chk("err_second", a_err, 1);
        at_cyc(1280); chk("short_frame_lines", a_fl, VT - 1);
        at_cyc(1567); chk("delayed_lock_early", a_lk, 0);
        at_cyc(1568); chk("delayed_lock", a_lk, 1); chk("delayed_lock_b", b_lk, 1);
        lit_done = 1'b1;
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 2'($urandom));
            chk("reset_locked", a_lk, 0); chk("reset_active", a_act, 0);
            chk("reset_line_len", a_ll, 0); chk("reset_b_locked", b_lk, 0);
        end
        rst = 1'b0;
        gen_frame(VT, -1, -1);
        gen_frame(VT, -1, -1);
        gen_frame(VT, -1, VS + VB);
        gen_frame(VT, 5, -1);
        gen_frame(VT, -1, -1);
        gen_frame(VT, -1, -1);
        gen_frame(VT, -1, -1);
        gen_frame(VT, 2, -1);
        gen_frame(VT - 1, -1, -1);
        gen_frame(VT, -1, -1);
        gen_frame(VT, -1, -1);
        gen_frame(VT, -1, -1);
        gen_frame(2, -1, -1);
        for (int i = 0; i < 500 && !lit_done; i++) @(negedge clk);
        chk("checkpoints_reached", lit_done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
